// File: rtl/imem_pkg.sv
// Shared types and default widths for the instruction-memory fetch unit.
package imem_pkg;

  typedef enum logic {RUN, LOAD} imem_state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 8;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W single-read/single-write synchronous RAM with a power-up program preset.
module imem_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DEPTH      = 2**ADDR_W,
  parameter int unsigned INIT_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_en,
  input  logic              i_rd_zero,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t f_preset();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = (i < INIT_WORDS) ? DATA_W'(i + 1) : '0;
    end
    return m;
  endfunction

  // Storage is preset at configuration time and never cleared by reset.
  mem_t r_mem = f_preset();

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_rd_idx = i_rd_addr[IDX_W-1:0];
  assign w_wr_idx = i_wr_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  // Read register only updates on an accepted fetch, so a stalled response holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_rd_data <= '0;
    end else if (i_rd_en) begin
      o_rd_data <= i_rd_zero ? '0 : r_mem[w_rd_idx];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with valid/ready fetch, 1-cycle stallable response and sequential program load.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DEPTH      = 2**ADDR_W,
  parameter int unsigned INIT_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  imem_state_e     r_state;
  logic [ADDR_W:0] r_load_cnt;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic            r_load_done;
  logic            r_load_err;

  logic w_accept;
  logic w_oob;
  logic w_cnt_full;
  logic w_we;

  assign req_ready  = (r_state == RUN) && (!r_resp_valid || resp_ready);
  assign w_accept   = req_valid && req_ready;
  assign w_oob      = {1'b0, req_addr} >= DEPTH_C;
  assign w_cnt_full = (r_load_cnt == DEPTH_C);
  // A beat coinciding with load_start is dropped; the restart takes priority.
  assign w_we       = rst_n && (r_state == LOAD) && load_valid && !load_start && !w_cnt_full;

  imem_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_WORDS(INIT_WORDS)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd_en  (w_accept),
    .i_rd_zero(w_oob),
    .i_rd_addr(req_addr),
    .o_rd_data(resp_data),
    .i_we     (w_we),
    .i_wr_addr(r_load_cnt[ADDR_W-1:0]),
    .i_wr_data(load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_load_cnt   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_load_done <= 1'b0;

      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_oob;
      end else if (resp_ready) begin
        r_resp_valid <= 1'b0;
      end

      case (r_state)
        RUN: begin
          if (load_start) begin
            r_state    <= LOAD;
            r_load_cnt <= '0;
            r_load_err <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            r_load_cnt <= '0;
            r_load_err <= 1'b0;
          end else if (load_valid) begin
            if (w_cnt_full) begin
              r_load_err <= 1'b1;
            end else begin
              r_load_cnt <= r_load_cnt + 1'b1;
            end
            if (load_last) begin
              r_state     <= RUN;
              r_load_done <= 1'b1;
            end
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed scenarios plus random traffic on a full-size and a DEPTH=4 instance.
module tb_imem_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid  [2];
  logic        resp_ready [2];
  logic        load_start [2];
  logic        load_valid [2];
  logic        load_last  [2];
  logic [7:0]  req_addr   [2];
  logic [31:0] load_data  [2];

  logic        a_req_ready, a_resp_valid, a_resp_err, a_load_done, a_load_err;
  logic [31:0] a_resp_data;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_load_done, b_load_err;
  logic [31:0] b_resp_data;

  imem_fetch_unit u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(a_req_ready), .req_addr(req_addr[0]),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready[0]),
    .resp_data(a_resp_data), .resp_err(a_resp_err),
    .load_start(load_start[0]), .load_valid(load_valid[0]), .load_data(load_data[0]),
    .load_last(load_last[0]), .load_done(a_load_done), .load_err(a_load_err)
  );

  imem_fetch_unit #(.DATA_W(32), .ADDR_W(3), .DEPTH(4), .INIT_WORDS(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(b_req_ready), .req_addr(req_addr[1][2:0]),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready[1]),
    .resp_data(b_resp_data), .resp_err(b_resp_err),
    .load_start(load_start[1]), .load_valid(load_valid[1]), .load_data(load_data[1]),
    .load_last(load_last[1]), .load_done(b_load_done), .load_err(b_load_err)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s unit%0d actual=%h required=%h t=%0t", nm, u, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: program image, load cursor and the one pending response per unit.
  logic [31:0] m_mem [2][256];
  int          m_depth [2] = '{256, 4};
  bit          m_loading [2];
  int          m_cursor [2];
  bit          m_pend [2];
  logic [31:0] m_pdata [2];
  bit          m_perr [2];
  bit          m_done [2];
  bit          m_lerr [2];

  initial begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 256; i++)
        m_mem[u][i] = (i < 8 && i < m_depth[u]) ? 32'(i + 1) : 32'h0;
  end

  function automatic int eff_addr(input int u);
    return (u == 0) ? int'(req_addr[0]) : int'(req_addr[1][2:0]);
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_loading[u] = 0; m_cursor[u] = 0; m_pend[u] = 0;
        m_pdata[u] = 0; m_perr[u] = 0; m_done[u] = 0; m_lerr[u] = 0;
      end else begin
        bit can_take;
        int a;
        can_take = !m_loading[u] && (!m_pend[u] || resp_ready[u]);
        a = eff_addr(u);
        if (req_valid[u] && can_take) begin
          m_pend[u]  = 1;
          m_perr[u]  = (a >= m_depth[u]);
          m_pdata[u] = m_perr[u] ? 32'h0 : m_mem[u][a];
        end else if (m_pend[u] && resp_ready[u]) begin
          m_pend[u] = 0;
        end
        m_done[u] = 0;
        if (load_start[u]) begin
          m_loading[u] = 1; m_cursor[u] = 0; m_lerr[u] = 0;
        end else if (m_loading[u] && load_valid[u]) begin
          if (m_cursor[u] < m_depth[u]) begin
            m_mem[u][m_cursor[u]] = load_data[u];
            m_cursor[u]++;
          end else begin
            m_lerr[u] = 1;
          end
          if (load_last[u]) begin
            m_loading[u] = 0;
            m_done[u]    = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        logic exp_ready;
        exp_ready = !m_loading[u] && (!m_pend[u] || resp_ready[u]);
        chk("m_req_ready", u, (u == 0) ? a_req_ready : b_req_ready, exp_ready);
        chk("m_resp_valid", u, (u == 0) ? a_resp_valid : b_resp_valid, m_pend[u]);
        chk("m_load_done", u, (u == 0) ? a_load_done : b_load_done, m_done[u]);
        chk("m_load_err", u, (u == 0) ? a_load_err : b_load_err, m_lerr[u]);
        if (m_pend[u]) begin
          chk("m_resp_data", u, (u == 0) ? a_resp_data : b_resp_data, m_pdata[u]);
          chk("m_resp_err", u, (u == 0) ? a_resp_err : b_resp_err, m_perr[u]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 0; resp_ready[u] = 1; load_start[u] = 0;
      load_valid[u] = 0; load_last[u] = 0; req_addr[u] = 0; load_data[u] = 0;
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick();
    chk_en = 1;
    tick();
    rst_n = 1;
    chk("rst_resp_valid", 0, a_resp_valid, 0);
    chk("rst_resp_data", 0, a_resp_data, 0);
    chk("rst_load_err", 1, b_load_err, 0);

    // Back-to-back fetch of the preset program
    for (int i = 0; i < 8; i++) begin
      req_valid[0] = 1; req_addr[0] = 8'(i);
      tick();
      chk("t1_data", 0, a_resp_data, 32'(i + 1));
      chk("t1_valid", 0, a_resp_valid, 1);
    end
    req_valid[0] = 0;
    tick();
    chk("t1_valid_fall", 0, a_resp_valid, 0);

    // Stalled response holds; next request waits
    req_valid[0] = 1; req_addr[0] = 3; resp_ready[0] = 0;
    tick();
    req_addr[0] = 5;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_data", 0, a_resp_data, 4);
      chk("t2_ready_low", 0, a_req_ready, 0);
      tick();
    end
    resp_ready[0] = 1;
    tick();
    chk("t2_next", 0, a_resp_data, 6);
    req_valid[0] = 0;
    tick();

    // Short program load then fetch
    load_start[0] = 1;
    tick();
    load_start[0] = 0;
    for (int k = 0; k < 3; k++) begin
      load_valid[0] = 1; load_data[0] = 32'hAABB0001 + 32'(k); load_last[0] = (k == 2);
      tick();
    end
    load_valid[0] = 0; load_last[0] = 0;
    chk("t3_done", 0, a_load_done, 1);
    tick();
    chk("t3_done_pulse", 0, a_load_done, 0);
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = 1; req_addr[0] = 8'(i);
      tick();
      chk("t3_fetch", 0, a_resp_data, (i < 3) ? 32'hAABB0001 + 32'(i) : 32'h4);
    end
    req_valid[0] = 0;
    tick();

    // Fetch coinciding with load_start sees old contents; no accepts while loading
    req_valid[0] = 1; req_addr[0] = 1; load_start[0] = 1;
    tick();
    load_start[0] = 0;
    chk("t5_old_data", 0, a_resp_data, 32'hAABB0002);
    for (int k = 0; k < 3; k++) begin
      load_valid[0] = 1; load_data[0] = 32'h55550000 + 32'(k); load_last[0] = (k == 2);
      chk("t5_ready_low", 0, a_req_ready, 0);
      tick();
    end
    load_valid[0] = 0; load_last[0] = 0;
    tick();
    chk("t5_new_data", 0, a_resp_data, 32'h55550001);
    req_valid[0] = 0;
    tick();

    // Reset in the middle of a load
    load_start[0] = 1;
    tick();
    load_start[0] = 0;
    for (int k = 0; k < 2; k++) begin
      load_valid[0] = 1; load_data[0] = 32'hCAFE0000 + 32'(k);
      tick();
    end
    load_data[0] = 32'hCAFE0002; rst_n = 0;
    tick();
    rst_n = 1; load_valid[0] = 0;
    chk("t6_valid", 0, a_resp_valid, 0);
    chk("t6_data", 0, a_resp_data, 0);
    chk("t6_ready", 0, a_req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      req_valid[0] = 1; req_addr[0] = 8'(i);
      tick();
      chk("t6_fetch", 0, a_resp_data, (i == 0) ? 32'hCAFE0000 : (i == 1) ? 32'hCAFE0001 : 32'h55550002);
    end
    req_valid[0] = 0;
    tick();

    // Small instance: out-of-range fetch and overlong load
    req_valid[1] = 1; req_addr[1] = 5;
    tick();
    req_valid[1] = 0;
    chk("t4_err", 1, b_resp_err, 1);
    chk("t4_zero", 1, b_resp_data, 0);
    load_start[1] = 1;
    tick();
    load_start[1] = 0;
    for (int k = 0; k < 6; k++) begin
      load_valid[1] = 1; load_data[1] = 32'hB0 + 32'(k); load_last[1] = (k == 5);
      tick();
    end
    load_valid[1] = 0; load_last[1] = 0;
    chk("t4_lerr", 1, b_load_err, 1);
    chk("t4_done", 1, b_load_done, 1);
    tick(); tick();
    chk("t4_lerr_sticky", 1, b_load_err, 1);
    for (int i = 0; i < 5; i++) begin
      req_valid[1] = 1; req_addr[1] = 8'(i);
      tick();
      chk("t4_fetch", 1, b_resp_data, (i < 4) ? 32'hB0 + 32'(i) : 32'h0);
      chk("t4_fetch_err", 1, b_resp_err, (i == 4));
    end
    req_valid[1] = 0;
    load_start[1] = 1;
    tick();
    load_start[1] = 0;
    chk("t4_lerr_clear", 1, b_load_err, 0);
    load_valid[1] = 1; load_data[1] = 32'hC0; load_last[1] = 1;
    tick();
    load_valid[1] = 0; load_last[1] = 0;
    tick();

    // Random traffic on both instances against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int u = 0; u < 2; u++) begin
        req_valid[u]  = 1'($urandom_range(0, 1));
        req_addr[u]   = (u == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
        resp_ready[u] = ($urandom_range(0, 3) != 0);
        load_start[u] = ($urandom_range(0, 39) == 0);
        load_valid[u] = 1'($urandom_range(0, 1));
        load_data[u]  = $urandom;
        load_last[u]  = ($urandom_range(0, 5) == 0);
      end
      tick();
    end
    rst_n = 1;
    idle();
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
